// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Time-shares a single external combinational W-bit adder among NREQ clients.
//   A round-robin arbiter picks one pending request, latches its operands onto
//   the adder inputs, waits one cycle for the adder to settle, then holds the
//   registered sum/carry with the owner's id until the consumer takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-client handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, client i at [i*W +: W]
//   req_cin               per-client carry-in
//   req_sub               (ADD_ARB_SUB_EN only) per-client subtract select
//   add_a/add_b/add_cin   registered operands to the external adder
//   add_sum/add_cout      result from the external adder
//   rsp_valid/rsp_ready   response handshake
//   rsp_sum/rsp_cout/rsp_id  registered result and owning client index
//
// Build option
//   ADD_ARB_SUB_EN  adds req_sub; a subtract op feeds ~b with carry-in 1.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight; accepting
// CALC  | operands on adder inputs, waiting one cycle for the sum to settle
// RESP  | result held on rsp_*; accepting only in the cycle it is consumed
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADD_ARB_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic           add_cin_q, add_cin_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           accept_win;
  logic           accept;
  logic [W-1:0]   sel_a, sel_b;
  logic           sel_cin;

  // Round-robin scan starting at rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Operand mux for the granted client; subtract is A + ~B + 1.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_cin = req_cin[i];
`ifdef ADD_ARB_SUB_EN
        if (req_sub[i]) begin
          sel_b   = ~req_b[i*W +: W];
          sel_cin = 1'b1;
        end
`endif
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held.
  assign accept_win = rst_n && ((state_q == S_IDLE) || (state_q == S_RESP && rsp_ready));
  assign accept     = accept_win && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_id_d   = id_q;
        state_d    = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = accept ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      add_a_d   = sel_a;
      add_b_d   = sel_b;
      add_cin_d = sel_cin;
      id_d      = grant_idx;
      rr_ptr_d  = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule
